// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic matrix multiply: fetches A, B (and optionally C)
// from a 1-cycle-latency scratchpad, runs the skewed MAC wavefront, then stores C.
module systolic_matmul_engine #(
  parameter int GRID_N = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              accumulate,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int NN       = GRID_N * GRID_N;
  localparam int CMP_LAST = 3 * GRID_N - 3;
  localparam int CNT_W    = $clog2(NN + 3 * GRID_N + 1);
  localparam int IDX_W    = $clog2(NN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_COMPUTE, S_STORE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_mode_q, acc_mode_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] c_base_q, c_base_d;
  logic              rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] rd_base;

  logic [DATA_W-1:0] a_op_q [NN];
  logic [DATA_W-1:0] a_op_d [NN];
  logic [DATA_W-1:0] b_op_q [NN];
  logic [DATA_W-1:0] b_op_d [NN];
  logic [DATA_W-1:0] acc_q  [NN];
  logic [DATA_W-1:0] acc_d  [NN];
  logic [DATA_W-1:0] w_q    [NN];
  logic [DATA_W-1:0] w_d    [NN];
  logic [DATA_W-1:0] n_q    [NN];
  logic [DATA_W-1:0] n_d    [NN];
  logic [DATA_W-1:0] west   [GRID_N];
  logic [DATA_W-1:0] north  [GRID_N];

  // Products wrap modulo 2^DATA_W, so only the low half of w*n is kept.
  function automatic logic [DATA_W-1:0] mac_wrap(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] w,
                                                 input logic [DATA_W-1:0] n);
    logic [DATA_W-1:0] prod;
    prod = w * n;
    return acc + prod;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_mode_d = acc_mode_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    c_base_d   = c_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD_A;
          cnt_d      = '0;
          acc_mode_d = accumulate;
          a_base_d   = a_base;
          b_base_d   = b_base;
          c_base_d   = c_base;
        end
      end
      S_LOAD_A, S_LOAD_B, S_LOAD_C: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NN)) begin
          cnt_d = '0;
          if (state_q == S_LOAD_A)                    state_d = S_LOAD_B;
          else if (state_q == S_LOAD_B && acc_mode_q) state_d = S_LOAD_C;
          else                                        state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CMP_LAST)) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NN - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
    case (state_q)
      S_LOAD_B: rd_base = b_base_q;
      S_LOAD_C: rd_base = c_base_q;
      default:  rd_base = a_base_q;
    endcase
    mem_rd_en   = (state_q == S_LOAD_A || state_q == S_LOAD_B || state_q == S_LOAD_C) &&
                  (cnt_q < CNT_W'(NN));
    mem_rd_addr = mem_rd_en ? rd_base + ADDR_W'(cnt_q) : '0;
    mem_wr_en   = (state_q == S_STORE);
    mem_wr_addr = mem_wr_en ? c_base_q + ADDR_W'(cnt_q) : '0;
    mem_wr_data = mem_wr_en ? acc_q[cnt_q[IDX_W-1:0]] : '0;
    rd_vld_d    = mem_rd_en;
    rd_idx_d    = cnt_q[IDX_W-1:0];
  end

  // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j].
  always_comb begin
    for (int i = 0; i < GRID_N; i++) begin
      west[i]  = '0;
      north[i] = '0;
      if (state_q == S_COMPUTE && int'(cnt_q) >= i && int'(cnt_q) - i < GRID_N) begin
        west[i]  = a_op_q[i * GRID_N + int'(cnt_q) - i];
        north[i] = b_op_q[(int'(cnt_q) - i) * GRID_N + i];
      end
    end
  end

  always_comb begin
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] n_in;
    int                k;
    w_in   = '0;
    n_in   = '0;
    k      = 0;
    a_op_d = a_op_q;
    b_op_d = b_op_q;
    acc_d  = acc_q;
    for (int m = 0; m < NN; m++) begin
      w_d[m] = '0;
      n_d[m] = '0;
    end
    // Read data lands one cycle after issue, still within the same LOAD state.
    if (rd_vld_q) begin
      case (state_q)
        S_LOAD_A: a_op_d[rd_idx_q] = mem_rd_data;
        S_LOAD_B: b_op_d[rd_idx_q] = mem_rd_data;
        S_LOAD_C: acc_d[rd_idx_q]  = mem_rd_data;
        default:  ;
      endcase
    end
    if (state_q == S_COMPUTE) begin
      for (int i = 0; i < GRID_N; i++) begin
        for (int j = 0; j < GRID_N; j++) begin
          k = i * GRID_N + j;
          if (j == 0) w_in = west[i];
          else        w_in = w_q[k - 1];
          if (i == 0) n_in = north[j];
          else        n_in = n_q[k - GRID_N];
          acc_d[k] = mac_wrap(acc_q[k], w_in, n_in);
          w_d[k]   = w_in;
          n_d[k]   = n_in;
        end
      end
    end
    if (state_d == S_COMPUTE && state_q != S_COMPUTE && !acc_mode_q) begin
      for (int m = 0; m < NN; m++) acc_d[m] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_mode_q <= 1'b0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      for (int m = 0; m < NN; m++) begin
        a_op_q[m] <= '0;
        b_op_q[m] <= '0;
        acc_q[m]  <= '0;
        w_q[m]    <= '0;
        n_q[m]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_mode_q <= acc_mode_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_base_q   <= c_base_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      a_op_q     <= a_op_d;
      b_op_q     <= b_op_d;
      acc_q      <= acc_d;
      w_q        <= w_d;
      n_q        <= n_d;
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench: a 2x2 and a 4x4 engine, each with its own scratchpad model.
module tb_systolic_matmul_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start0, acc0, busy0, done0, rd_en0, wr_en0;
  logic [4:0]  ab0, bb0, cb0, rd_addr0, wr_addr0;
  logic [15:0] rd_data0 = '0;
  logic [15:0] wr_data0;
  logic        start1, acc1, busy1, done1, rd_en1, wr_en1;
  logic [5:0]  ab1, bb1, cb1, rd_addr1, wr_addr1;
  logic [15:0] rd_data1 = '0;
  logic [15:0] wr_data1;

  systolic_matmul_engine #(.GRID_N(2), .DATA_W(16), .ADDR_W(5)) u0 (
    .clk(clk), .rst(rst), .start(start0), .accumulate(acc0),
    .a_base(ab0), .b_base(bb0), .c_base(cb0), .busy(busy0), .done(done0),
    .mem_rd_en(rd_en0), .mem_rd_addr(rd_addr0), .mem_rd_data(rd_data0),
    .mem_wr_en(wr_en0), .mem_wr_addr(wr_addr0), .mem_wr_data(wr_data0));

  systolic_matmul_engine #(.GRID_N(4), .DATA_W(16), .ADDR_W(6)) u1 (
    .clk(clk), .rst(rst), .start(start1), .accumulate(acc1),
    .a_base(ab1), .b_base(bb1), .c_base(cb1), .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rd_data1),
    .mem_wr_en(wr_en1), .mem_wr_addr(wr_addr1), .mem_wr_data(wr_data1));

  logic [15:0] mem0 [32];
  logic [15:0] img0 [32];
  logic [15:0] mem1 [64];
  logic [15:0] img1 [64];
  logic        load0, load1;

  always @(posedge clk) begin
    if (load0)       mem0 = img0;
    else if (wr_en0) mem0[wr_addr0] = wr_data0;
    if (rd_en0) rd_data0 <= mem0[rd_addr0];
  end

  always @(posedge clk) begin
    if (load1)       mem1 = img1;
    else if (wr_en1) mem1[wr_addr1] = wr_data1;
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
  end

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  logic [4:0] rd_log[$];
  logic       rec_rd = 1'b0;
  int checks = 0, errors = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain matrix product over the pre-run memory image.
  task automatic push_exp0(input logic [4:0] ab, input logic [4:0] bb, input logic [4:0] cb,
                           input logic acc);
    logic [4:0] ad, aa, ba;
    logic [15:0] s;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ad = cb + 5'(r * 2 + c);
        s  = acc ? img0[ad] : 16'h0;
        for (int k = 0; k < 2; k++) begin
          aa = ab + 5'(r * 2 + k);
          ba = bb + 5'(k * 2 + c);
          s  = s + img0[aa] * img0[ba];
        end
        q0.push_back('{addr: 6'(ad), data: s});
      end
  endtask

  task automatic push_exp1(input logic [5:0] ab, input logic [5:0] bb, input logic [5:0] cb,
                           input logic acc);
    logic [5:0] ad, aa, ba;
    logic [15:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ad = cb + 6'(r * 4 + c);
        s  = acc ? img1[ad] : 16'h0;
        for (int k = 0; k < 4; k++) begin
          aa = ab + 6'(r * 4 + k);
          ba = bb + 6'(k * 4 + c);
          s  = s + img1[aa] * img1[ba];
        end
        q1.push_back('{addr: ad, data: s});
      end
  endtask

  initial forever begin
    wr_t e;
    @(negedge clk);
    if (done0) done_cnt0++;
    if (rec_rd && rd_en0 && rd_log.size() < 4) rd_log.push_back(rd_addr0);
    if (wr_en0) begin
      wr_cnt0++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr0_unexpected actual addr=%0d data=%0d expected no write", wr_addr0, wr_data0);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", 32'(wr_addr0), 32'(e.addr));
        chk("wr0_data", 32'(wr_data0), 32'(e.data));
      end
    end
  end

  initial forever begin
    wr_t e;
    @(negedge clk);
    if (done1) done_cnt1++;
    if (wr_en1) begin
      wr_cnt1++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr1_unexpected actual addr=%0d data=%0d expected no write", wr_addr1, wr_data1);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(wr_addr1), 32'(e.addr));
        chk("wr1_data", 32'(wr_data1), 32'(e.data));
      end
    end
  end

  task automatic run0(input logic [4:0] ab, input logic [4:0] bb, input logic [4:0] cb,
                      input logic acc, input int pulse_at);
    int n, busy_cnt, wc, dc;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    push_exp0(ab, bb, cb, acc);
    wc = wr_cnt0; dc = done_cnt0;
    ab0 = ab; bb0 = bb; cb0 = cb; acc0 = acc; start0 = 1'b1;
    n = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      start0 = (n == pulse_at);
      acc0 = 1'b0;
      if (busy0) busy_cnt++;
    end while (!done0 && n < 1000);
    start0 = 1'b0;
    chk("busy_cycles0", 32'(busy_cnt), acc ? 32'd23 : 32'd18);
    chk("done_cycle0", 32'(n), acc ? 32'd24 : 32'd19);
    repeat (3) @(negedge clk);
    chk("writes0", 32'(wr_cnt0 - wc), 32'd4);
    chk("done_pulses0", 32'(done_cnt0 - dc), 32'd1);
    chk("sb0_empty", 32'(q0.size()), 32'd0);
  endtask

  task automatic run1(input logic [5:0] ab, input logic [5:0] bb, input logic [5:0] cb,
                      input logic acc);
    int n, busy_cnt, wc, dc, last_rd, first_wr;
    load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    push_exp1(ab, bb, cb, acc);
    wc = wr_cnt1; dc = done_cnt1;
    ab1 = ab; bb1 = bb; cb1 = cb; acc1 = acc; start1 = 1'b1;
    n = 0; busy_cnt = 0; last_rd = 0; first_wr = -1;
    do begin
      @(negedge clk);
      n++;
      start1 = 1'b0;
      if (busy1) busy_cnt++;
      if (rd_en1) last_rd = n;
      if (wr_en1 && first_wr < 0) first_wr = n;
    end while (!done1 && n < 2000);
    chk("busy_cycles1", 32'(busy_cnt), acc ? 32'd77 : 32'd60);
    chk("compute_len1", 32'(first_wr - last_rd - 2), 32'd10);
    repeat (3) @(negedge clk);
    chk("writes1", 32'(wr_cnt1 - wc), 32'd16);
    chk("done_pulses1", 32'(done_cnt1 - dc), 32'd1);
    chk("sb1_empty", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int wc, n;
    logic [4:0] exp_rd [4];
    rst = 1'b1; load0 = 1'b0; load1 = 1'b0;
    start0 = 1'b0; acc0 = 1'b0; ab0 = '0; bb0 = '0; cb0 = '0;
    start1 = 1'b0; acc1 = 1'b0; ab1 = '0; bb1 = '0; cb1 = '0;
    for (int i = 0; i < 32; i++) img0[i] = '0;
    for (int i = 0; i < 64; i++) img1[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_rd_en0", 32'(rd_en0), 32'd0);
    chk("rst_wr_en0", 32'(wr_en0), 32'd0);
    chk("rst_rd_addr0", 32'(rd_addr0), 32'd0);
    chk("rst_wr_addr0", 32'(wr_addr0), 32'd0);
    chk("rst_wr_data0", 32'(wr_data0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    rst = 1'b0;

    img0[0] = 1; img0[1] = 2; img0[2] = 3; img0[3] = 4;
    img0[4] = 5; img0[5] = 6; img0[6] = 7; img0[7] = 8;
    run0(5'd0, 5'd4, 5'd8, 1'b0, 0);
    for (int i = 8; i < 12; i++) img0[i] = 16'd1;
    run0(5'd0, 5'd4, 5'd8, 1'b1, 0);

    for (int i = 0; i < 4; i++) begin img0[i] = 16'h00FF; img0[4 + i] = 16'h0101; end
    run0(5'd0, 5'd4, 5'd8, 1'b0, 0);

    img0[30] = 1; img0[31] = 2; img0[0] = 3; img0[1] = 4;
    img0[4] = 5; img0[5] = 6; img0[6] = 7; img0[7] = 8;
    rd_log.delete();
    rec_rd = 1'b1;
    run0(5'd30, 5'd4, 5'd8, 1'b0, 0);
    rec_rd = 1'b0;
    exp_rd[0] = 5'd30; exp_rd[1] = 5'd31; exp_rd[2] = 5'd0; exp_rd[3] = 5'd1;
    chk("wrap_rd_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_rd_addr", 32'(rd_log[i]), 32'(exp_rd[i]));

    img0[0] = 1; img0[1] = 2; img0[2] = 3; img0[3] = 4;
    run0(5'd0, 5'd4, 5'd8, 1'b0, 12);

    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    push_exp0(5'd0, 5'd4, 5'd8, 1'b0);
    wc = wr_cnt0;
    ab0 = 5'd0; bb0 = 5'd4; cb0 = 5'd8; acc0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!wr_en0 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_wr_en", 32'(wr_en0), 32'd0);
    chk("abort_sb_left", 32'(q0.size()), 32'd3);
    q0.delete();
    repeat (5) @(negedge clk);
    chk("abort_writes", 32'(wr_cnt0 - wc), 32'd1);
    run0(5'd0, 5'd4, 5'd8, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) img0[i] = 16'($urandom);
      run0(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 0);
    end

    for (int i = 0; i < 64; i++) img1[i] = '0;
    for (int i = 0; i < 4; i++) img1[i * 4 + i] = 16'd1;
    for (int i = 0; i < 16; i++) img1[16 + i] = 16'(i + 1);
    run1(6'd0, 6'd16, 6'd32, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) img1[i] = 16'($urandom);
      run1(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
